// File: rtl/esc_arm_sequencer.sv
// Arming / spin-up / run / spin-down sequencer for four ESC channels.
// Throttle updates are slew limited and aligned to the PWM frame boundary.
module esc_arm_sequencer #(
    parameter int CLK_PER_US = 50,
    parameter int FRAME_US   = 2500,
    parameter int ARM_FRAMES = 800,
    parameter int SLEW       = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        arm_req,
    input  logic        disarm_req,
    input  logic        kill,
    input  logic [31:0] throttle_cmd,
    output logic [31:0] throttle_out,
    output logic        idle,
    output logic        armed,
    output logic [1:0]  state,
    output logic        frame_tick
);

    localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int FW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
    localparam int AW = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(FRAME_US - 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_FRAMES - 1);
    localparam logic [8:0]    SLEW9    = 9'(SLEW);
    localparam logic [7:0]    SLEW8    = 8'(SLEW);

    typedef enum logic [2:0] {
        S_DISARMED,
        S_ARMING,
        S_SPINUP,
        S_RUN,
        S_SPINDOWN
    } fsm_t;

    fsm_t            fsm_reg;
    logic [AW-1:0]   arm_cnt_reg;
    logic [PW-1:0]   pre_reg;
    logic [FW-1:0]   frm_reg;
    logic            pre_wrap;
    logic            frame_wrap;
    logic [31:0]     track_all;
    logic [31:0]     spin_all;
    logic            all_at_cmd;
    logic            all_zero;

    assign pre_wrap   = (pre_reg == PRE_LAST);
    assign frame_wrap = pre_wrap && (frm_reg == FRM_LAST);

    // Free-running frame timer; only reset touches it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_reg    <= '0;
            frm_reg    <= '0;
            frame_tick <= 1'b0;
        end else begin
            pre_reg    <= pre_wrap ? '0 : pre_reg + 1'b1;
            if (pre_wrap)
                frm_reg <= frame_wrap ? '0 : frm_reg + 1'b1;
            frame_tick <= frame_wrap;
        end
    end

    // Per-channel next values: tracking toward cmd, and ramp toward zero.
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        logic [7:0] cur;
        logic [7:0] cmd;
        logic [8:0] up_diff;
        logic [8:0] dn_diff;
        logic [7:0] up_step;
        logic [7:0] dn_step;

        assign cur     = throttle_out[gi*8 +: 8];
        assign cmd     = throttle_cmd[gi*8 +: 8];
        assign up_diff = {1'b0, cmd} - {1'b0, cur};
        assign dn_diff = {1'b0, cur} - {1'b0, cmd};
        assign up_step = cur + SLEW8;
        assign dn_step = cur - SLEW8;

        assign track_all[gi*8 +: 8] =
            (cmd > cur) ? ((up_diff > SLEW9) ? up_step : cmd) :
            (cmd < cur) ? ((dn_diff > SLEW9) ? dn_step : cmd) : cur;
        assign spin_all[gi*8 +: 8]  = (cur > SLEW8) ? dn_step : 8'd0;
    end

    assign all_at_cmd = (track_all == throttle_cmd);
    assign all_zero   = (spin_all == 32'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg      <= S_DISARMED;
            arm_cnt_reg  <= '0;
            throttle_out <= '0;
            idle         <= 1'b1;
            armed        <= 1'b0;
            state        <= 2'd0;
        end else if (kill) begin
            fsm_reg      <= S_DISARMED;
            throttle_out <= '0;
            idle         <= 1'b1;
            armed        <= 1'b0;
            state        <= 2'd0;
        end else begin
            case (fsm_reg)
                S_DISARMED: begin
                    if (arm_req && !disarm_req) begin
                        fsm_reg     <= S_ARMING;
                        arm_cnt_reg <= '0;
                        state       <= 2'd1;
                    end
                end
                S_ARMING: begin
                    if (disarm_req) begin
                        fsm_reg <= S_DISARMED;
                        state   <= 2'd0;
                    end else if (frame_tick) begin
                        if (arm_cnt_reg == ARM_LAST) begin
                            fsm_reg <= S_SPINUP;
                            idle    <= 1'b0;
                            armed   <= 1'b1;
                            state   <= 2'd2;
                        end else begin
                            arm_cnt_reg <= arm_cnt_reg + 1'b1;
                        end
                    end
                end
                S_SPINUP, S_RUN: begin
                    if (disarm_req) begin
                        fsm_reg <= S_SPINDOWN;
                        armed   <= 1'b0;
                        state   <= 2'd3;
                    end else if (frame_tick) begin
                        throttle_out <= track_all;
                        if (all_at_cmd)
                            fsm_reg <= S_RUN;
                    end
                end
                S_SPINDOWN: begin
                    if (frame_tick) begin
                        throttle_out <= spin_all;
                        if (all_zero) begin
                            fsm_reg <= S_DISARMED;
                            idle    <= 1'b1;
                            state   <= 2'd0;
                        end
                    end
                end
                default: begin
                    fsm_reg      <= S_DISARMED;
                    throttle_out <= '0;
                    idle         <= 1'b1;
                    armed        <= 1'b0;
                    state        <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esc_arm_sequencer.sv
// Directed, table-driven bench for esc_arm_sequencer (tick every 20 cycles).
module tb_esc_arm_sequencer;

    logic        clock;
    logic        reset_n;
    logic        arm_req;
    logic        disarm_req;
    logic        kill;
    logic [31:0] throttle_cmd;
    logic [31:0] throttle_out;
    logic        idle;
    logic        armed;
    logic [1:0]  state;
    logic        frame_tick;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] exp_out;
        logic [1:0]  exp_state;
        logic        exp_idle;
        logic        exp_armed;
    } vec_t;

    vec_t vecs [9];

    esc_arm_sequencer #(
        .CLK_PER_US(2),
        .FRAME_US  (10),
        .ARM_FRAMES(3),
        .SLEW      (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .arm_req     (arm_req),
        .disarm_req  (disarm_req),
        .kill        (kill),
        .throttle_cmd(throttle_cmd),
        .throttle_out(throttle_out),
        .idle        (idle),
        .armed       (armed),
        .state       (state),
        .frame_tick  (frame_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string name, input logic [1:0] st, input logic id, input logic ar);
        check({name, "_state"}, 32'(state), 32'(st));
        check({name, "_idle"},  32'(idle),  32'(id));
        check({name, "_armed"}, 32'(armed), 32'(ar));
    endtask

    // Advance to the negedge after the next frame_tick cycle (outputs updated).
    task automatic next_frame();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_tick && n < 60);
        check("frame_tick_seen", 32'(frame_tick), 32'd1);
        @(negedge clock);
    endtask

    task automatic pulse(input logic a, input logic d);
        arm_req    = a;
        disarm_req = d;
        @(negedge clock);
        arm_req    = 1'b0;
        disarm_req = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            throttle_cmd = vecs[i].cmd;
            next_frame();
            $display("[TB] row %0d cmd=%h out=%h state=%0d idle=%0b armed=%0b",
                     i, vecs[i].cmd, throttle_out, state, idle, armed);
            check($sformatf("row%0d_out", i), throttle_out, vecs[i].exp_out);
            check_flags($sformatf("row%0d", i), vecs[i].exp_state, vecs[i].exp_idle, vecs[i].exp_armed);
        end
    endtask

    initial begin
        logic [7:0] e;
        int guard;

        vecs[0] = '{32'h0A0A0A0A, 32'h00000000, 2'd1, 1'b1, 1'b0};
        vecs[1] = '{32'h0A0A0A0A, 32'h00000000, 2'd1, 1'b1, 1'b0};
        vecs[2] = '{32'h0A0A0A0A, 32'h00000000, 2'd2, 1'b0, 1'b1};
        vecs[3] = '{32'h0A0A0A0A, 32'h04040404, 2'd2, 1'b0, 1'b1};
        vecs[4] = '{32'h0A0A0A0A, 32'h08080808, 2'd2, 1'b0, 1'b1};
        vecs[5] = '{32'h0A0A0A0A, 32'h0A0A0A0A, 2'd2, 1'b0, 1'b1};
        vecs[6] = '{32'h0A000A0A, 32'h06000606, 2'd3, 1'b0, 1'b0};
        vecs[7] = '{32'h0A000A0A, 32'h02000202, 2'd3, 1'b0, 1'b0};
        vecs[8] = '{32'h0A000A0A, 32'h00000000, 2'd0, 1'b1, 1'b0};

        reset_n      = 1'b0;
        arm_req      = 1'b0;
        disarm_req   = 1'b0;
        kill         = 1'b0;
        throttle_cmd = 32'h0;

        // Reset values, then 100 idle cycles with a tick every 20th.
        #25;
        check("reset_out", throttle_out, 32'h0);
        check("reset_tick", 32'(frame_tick), 32'd0);
        check_flags("reset", 2'd0, 1'b1, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            check($sformatf("idle_tick_c%0d", n), 32'(frame_tick), 32'((n % 20) == 0));
            check($sformatf("idle_out_c%0d", n), throttle_out, 32'h0);
            check_flags($sformatf("idle_c%0d", n), 2'd0, 1'b1, 1'b0);
        end
        $display("[TB] idle window done");

        // Arm and spin up to 10 on every channel.
        throttle_cmd = 32'h0A0A0A0A;
        pulse(1'b1, 1'b0);
        $display("[TB] arm_req state=%0d", state);
        check_flags("arm_entry", 2'd1, 1'b1, 1'b0);
        run_rows(0, 5);

        // Mid-frame command change on ch2 must wait for the tick.
        repeat (4) @(negedge clock);
        throttle_cmd = 32'h0AFF0A0A;
        repeat (3) @(negedge clock);
        check("midframe_hold", throttle_out, 32'h0A0A0A0A);
        e = 8'd10;
        guard = 0;
        while (e != 8'd255 && guard < 80) begin
            e = (8'd255 - e > 8'd4) ? e + 8'd4 : 8'd255;
            next_frame();
            $display("[TB] ramp up ch2 out=%h", throttle_out);
            check("ramp_up", throttle_out, {8'h0A, e, 8'h0A, 8'h0A});
            guard++;
        end
        next_frame();
        check("hold_255", throttle_out, 32'h0AFF0A0A);
        throttle_cmd = 32'h0A000A0A;
        guard = 0;
        while (e != 8'd0 && guard < 80) begin
            e = (e > 8'd4) ? e - 8'd4 : 8'd0;
            next_frame();
            $display("[TB] ramp down ch2 out=%h", throttle_out);
            check("ramp_down", throttle_out, {8'h0A, e, 8'h0A, 8'h0A});
            guard++;
        end

        // Controlled spin-down.
        pulse(1'b0, 1'b1);
        $display("[TB] disarm_req state=%0d out=%h", state, throttle_out);
        check_flags("disarm_entry", 2'd3, 1'b0, 1'b0);
        check("disarm_entry_out", throttle_out, 32'h0A000A0A);
        run_rows(6, 8);

        // Re-arm to RUN, then kill mid-frame.
        throttle_cmd = 32'h0A0A0A0A;
        pulse(1'b1, 1'b0);
        repeat (6) next_frame();
        check("rearm_run_out", throttle_out, 32'h0A0A0A0A);
        check_flags("rearm_run", 2'd2, 1'b0, 1'b1);
        repeat (3) @(negedge clock);
        kill = 1'b1;
        @(negedge clock);
        $display("[TB] kill state=%0d out=%h idle=%0b", state, throttle_out, idle);
        check("kill_out", throttle_out, 32'h0);
        check_flags("kill", 2'd0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check_flags("kill_blocks_arm", 2'd0, 1'b1, 1'b0);
        next_frame();
        check_flags("kill_held_frame", 2'd0, 1'b1, 1'b0);
        kill = 1'b0;
        @(negedge clock);
        check_flags("kill_release", 2'd0, 1'b1, 1'b0);

        // Simultaneous arm and disarm in DISARMED.
        pulse(1'b1, 1'b1);
        $display("[TB] arm+disarm state=%0d", state);
        check_flags("arm_disarm_same", 2'd0, 1'b1, 1'b0);
        next_frame();
        check_flags("arm_disarm_frame", 2'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of SPINUP.
        pulse(1'b1, 1'b0);
        repeat (3) next_frame();
        check_flags("spinup_again", 2'd2, 1'b0, 1'b1);
        next_frame();
        check("spinup_step", throttle_out, 32'h04040404);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        $display("[TB] async reset out=%h state=%0d idle=%0b", throttle_out, state, idle);
        check("areset_out", throttle_out, 32'h0);
        check("areset_tick", 32'(frame_tick), 32'd0);
        check_flags("areset", 2'd0, 1'b1, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            check($sformatf("post_reset_tick_c%0d", n), 32'(frame_tick), 32'(n == 20));
        end
        check_flags("post_reset", 2'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
